soml_frame_loader: RTL

SOML_FRAME_LOADER -- requirements
Module: soml_frame_loader

---
 rtl/soml_frame_loader.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/soml_frame_loader.sv
// Purpose: UART byte-stream frame loader for H/Y matrices (sync 0xA5, type, payload[, XOR checksum]); optional checksum via SOML_LOADER_CHKSUM_EN.
// Latency: element write strobe one cycle after its last byte; start/h_loaded update in the single COMMIT cycle after the last frame byte.
// Backpressure: none -- every rx_valid byte is consumed; an idle gap of TMO_CYC cycles mid-frame aborts the frame.
module soml_frame_loader #(
  parameter int N       = 32,
  parameter int NR      = 4,
  parameter int NT      = 4,
  parameter int NYCOL   = 2,
  parameter int TMO_CYC = 100000,
  localparam int RW     = (NR > 1) ? $clog2(NR) : 1,
  localparam int MAXC   = (NT > NYCOL) ? NT : NYCOL,
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          wr_en,
  output logic          wr_tgt,
  output logic [RW-1:0] wr_row,
  output logic [CW-1:0] wr_col,
  output logic [N-1:0]  wr_re,
  output logic [N-1:0]  wr_im,
  output logic          start,
  output logic          h_loaded,
  output logic          frame_err,
  output logic          busy
);

  localparam int EB  = 2 * (N / 8);          // bytes per complex element
  localparam int BCW = $clog2(EB);
  localparam int TW  = $clog2(TMO_CYC);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TYPE    = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
`ifdef SOML_LOADER_CHKSUM_EN
  localparam logic [2:0] S_CHK     = 3'd3;
`endif
  localparam logic [2:0] S_COMMIT  = 3'd4;

  localparam logic [BCW-1:0] BCNT_LAST = BCW'(EB - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(NR - 1);
  localparam logic [CW-1:0]  HCOL_LAST = CW'(NT - 1);
  localparam logic [CW-1:0]  YCOL_LAST = CW'(NYCOL - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TMO_CYC - 1);

  logic [2:0]       state_q,  state_d;
  logic [BCW-1:0]   bcnt_q,   bcnt_d;
  logic [RW-1:0]    row_q,    row_d;
  logic [CW-1:0]    col_q,    col_d;
  logic [2*N-9:0]   sh_q,     sh_d;
  logic             is_y_q,   is_y_d;
  logic [TW-1:0]    tmo_q,    tmo_d;
  logic             wr_en_q,  wr_en_d;
  logic             wr_tgt_q, wr_tgt_d;
  logic [RW-1:0]    wr_row_q, wr_row_d;
  logic [CW-1:0]    wr_col_q, wr_col_d;
  logic [N-1:0]     wr_re_q,  wr_re_d;
  logic [N-1:0]     wr_im_q,  wr_im_d;
  logic             start_q,  start_d;
  logic             err_q,    err_d;
  logic             hl_q,     hl_d;
`ifdef SOML_LOADER_CHKSUM_EN
  logic [7:0]       chk_q,    chk_d;
`endif

  logic [2*N-1:0]   next_word;
  logic             last_elem;

  // Element assembly: bytes shift in MSB first, real word ends up in the upper half.
  assign next_word = {sh_q, rx_data};
  assign last_elem = is_y_q ? ((col_q == YCOL_LAST) && (row_q == ROW_LAST))
                            : ((row_q == ROW_LAST) && (col_q == HCOL_LAST));

  // Next-state logic: frame parsing, element addressing, commit and timeout handling.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    row_d    = row_q;
    col_d    = col_q;
    sh_d     = sh_q;
    is_y_d   = is_y_q;
    tmo_d    = tmo_q;
    wr_en_d  = 1'b0;
    wr_tgt_d = wr_tgt_q;
    wr_row_d = wr_row_q;
    wr_col_d = wr_col_q;
    wr_re_d  = wr_re_q;
    wr_im_d  = wr_im_q;
    start_d  = 1'b0;
    err_d    = 1'b0;
    hl_d     = hl_q;
`ifdef SOML_LOADER_CHKSUM_EN
    chk_d    = chk_q;
`endif

    case (state_q)
      // COMMIT treats any byte as an IDLE byte so back-to-back frames are not lost.
      S_IDLE, S_COMMIT: begin
        state_d = S_IDLE;
        tmo_d   = '0;
        if (rx_valid && (rx_data == 8'hA5)) state_d = S_TYPE;
      end
      S_TYPE: begin
        if (rx_valid) begin
          if ((rx_data == 8'h01) || (rx_data == 8'h02)) begin
            state_d = S_PAYLOAD;
            is_y_d  = (rx_data == 8'h02);
            bcnt_d  = '0;
            row_d   = '0;
            col_d   = '0;
`ifdef SOML_LOADER_CHKSUM_EN
            chk_d   = 8'h00;
`endif
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          sh_d = next_word[2*N-9:0];
`ifdef SOML_LOADER_CHKSUM_EN
          chk_d = chk_q ^ rx_data;
`endif
          if (bcnt_q == BCNT_LAST) begin
            bcnt_d   = '0;
            wr_en_d  = 1'b1;
            wr_tgt_d = is_y_q;
            wr_row_d = row_q;
            wr_col_d = col_q;
            wr_re_d  = next_word[2*N-1:N];
            wr_im_d  = next_word[N-1:0];
            // H walks row-major, Y walks column-major.
            if (is_y_q) begin
              if (row_q == ROW_LAST) begin
                row_d = '0;
                col_d = col_q + 1'b1;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              if (col_q == HCOL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
            if (last_elem) begin
`ifdef SOML_LOADER_CHKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_COMMIT;
              if (is_y_q) start_d = hl_q;
              else        hl_d    = 1'b1;
`endif
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
`ifdef SOML_LOADER_CHKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d = S_COMMIT;
            if (is_y_q) start_d = hl_q;
            else        hl_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            if (!is_y_q) hl_d = 1'b0;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; the frame type is only known once past TYPE.
    if ((state_q != S_IDLE) && (state_q != S_COMMIT)) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        state_d = S_IDLE;
        err_d   = 1'b1;
        if ((state_q != S_TYPE) && !is_y_q) hl_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      sh_q     <= '0;
      is_y_q   <= 1'b0;
      tmo_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_tgt_q <= 1'b0;
      wr_row_q <= '0;
      wr_col_q <= '0;
      wr_re_q  <= '0;
      wr_im_q  <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      hl_q     <= 1'b0;
`ifdef SOML_LOADER_CHKSUM_EN
      chk_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sh_q     <= sh_d;
      is_y_q   <= is_y_d;
      tmo_q    <= tmo_d;
      wr_en_q  <= wr_en_d;
      wr_tgt_q <= wr_tgt_d;
      wr_row_q <= wr_row_d;
      wr_col_q <= wr_col_d;
      wr_re_q  <= wr_re_d;
      wr_im_q  <= wr_im_d;
      start_q  <= start_d;
      err_q    <= err_d;
      hl_q     <= hl_d;
`ifdef SOML_LOADER_CHKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_tgt    = wr_tgt_q;
  assign wr_row    = wr_row_q;
  assign wr_col    = wr_col_q;
  assign wr_re     = wr_re_q;
  assign wr_im     = wr_im_q;
  assign start     = start_q;
  assign frame_err = err_q;
  assign h_loaded  = hl_q;
  assign busy      = (state_q != S_IDLE);

endmodule
